// File: rtl/motor_grade_n_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkg_grade
// Brief    : Shared types and helpers for the light-cycle grid engine.
// Revision : 1.0 - initial release
// ============================================================================
package pkg_grade;

    localparam logic [1:0] C_DIR_DIREITA  = 2'd0;
    localparam logic [1:0] C_DIR_BAIXO    = 2'd1;
    localparam logic [1:0] C_DIR_ESQUERDA = 2'd2;
    localparam logic [1:0] C_DIR_CIMA     = 2'd3;

    typedef enum logic [1:0] {
        LIMPA = 2'd0,
        JOGA  = 2'd1,
        PAUSA = 2'd2,
        FIM   = 2'd3
    } estado_t;

    typedef enum logic [1:0] {
        F_OCIOSO = 2'd0,
        F_CALC   = 2'd1,
        F_AVALIA = 2'd2,
        F_GRAVA  = 2'd3
    } fase_t;

    // Trail of player i is i+1; the wall takes the code just above the last player.
    function automatic int cod_celula(input int jogador, input int n_jog, input bit parede);
        return parede ? n_jog + 1 : jogador + 1;
    endfunction

    function automatic int col_inicio(input int i, input int n_jog, input int cols, input int borda);
        return borda + ((i + 1) * (cols - 2 * borda)) / (n_jog + 1);
    endfunction

    function automatic int lin_inicio(input int rows);
        return rows / 2;
    endfunction

    function automatic logic [1:0] dir_inicio(input int i);
        return (i % 2 == 0) ? C_DIR_DIREITA : C_DIR_ESQUERDA;
    endfunction

endpackage
`default_nettype wire

// File: rtl/motor_grade_n_ram.sv
`default_nettype none
// ============================================================================
// Module   : ram_grade
// Brief    : Simple dual-port synchronous grid RAM (port A r/w, port B read).
// Revision : 1.0 - initial release
// ============================================================================
module ram_grade
    import pkg_grade::*;
#(
    parameter int DEPTH = 4800,
    parameter int CW    = 2,
    parameter int AW    = 13
)(
    input  logic          clk_i,
    input  logic          we_a_i,
    input  logic [AW-1:0] addr_a_i,
    input  logic [CW-1:0] wdata_a_i,
    output logic [CW-1:0] rdata_a_o,
    input  logic [AW-1:0] addr_b_i,
    output logic [CW-1:0] rdata_b_o
);

    logic [CW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_a_i) begin
            mem_q[addr_a_i] <= wdata_a_i;
        end
        rdata_a_o <= mem_q[addr_a_i];
        rdata_b_o <= mem_q[addr_b_i];
    end

endmodule
`default_nettype wire

// File: rtl/motor_grade_n.sv
`default_nettype none
// ============================================================================
// Module   : motor_grade_n
// Brief    : N-player light-cycle engine: wall sweep, stepping, trails, wins.
// Revision : 1.0 - initial release
// ============================================================================
module motor_grade_n
    import pkg_grade::*;
#(
    parameter int N_JOG   = 2,
    parameter int COLS    = 80,
    parameter int ROWS    = 60,
    parameter int BORDA   = 2,
    parameter int PERIODO = 2000000
)(
    input  logic                       CLOCK_50,
    input  logic                       reset_n,
    input  logic                       reiniciar,
    input  logic                       pausa,
    input  logic [N_JOG-1:0]           gira_h,
    input  logic [N_JOG-1:0]           gira_ah,
    input  logic [6:0]                 rd_col,
    input  logic [5:0]                 rd_lin,
    output logic [$clog2(N_JOG+2)-1:0] rd_dado,
    output logic [N_JOG*7-1:0]         cab_col,
    output logic [N_JOG*6-1:0]         cab_lin,
    output logic [N_JOG-1:0]           vivos,
    output logic [1:0]                 estado,
    output logic [2:0]                 vencedor,
    output logic                       passo_ok
);

    localparam int C_CW    = $clog2(N_JOG + 2);
    localparam int C_NCELL = ROWS * COLS;
    localparam int C_AW    = $clog2(C_NCELL);
    localparam int C_TW    = $clog2(PERIODO);
    localparam logic [C_TW-1:0] C_TMR_FIM   = C_TW'(PERIODO - 1);
    localparam logic [C_AW-1:0] C_ULT_CEL   = C_AW'(C_NCELL - 1);
    localparam logic [5:0]      C_LIN_INI   = 6'(lin_inicio(ROWS));
    localparam logic [5:0]      C_LIN_MIN   = 6'(BORDA);
    localparam logic [5:0]      C_LIN_MAX   = 6'(ROWS - BORDA);
    localparam logic [5:0]      C_LIN_ULT   = 6'(ROWS - 1);
    localparam logic [6:0]      C_COL_MIN   = 7'(BORDA);
    localparam logic [6:0]      C_COL_MAX   = 7'(COLS - BORDA);
    localparam logic [6:0]      C_COL_ULT   = 7'(COLS - 1);
    localparam logic [2:0]      C_ULT_AVAL  = 3'(N_JOG);
    localparam logic [2:0]      C_ULT_GRAVA = 3'(N_JOG - 1);
    localparam logic [C_CW-1:0] C_PAREDE    = C_CW'(cod_celula(0, N_JOG, 1'b1));

    function automatic logic [C_AW-1:0] endereco(input logic [5:0] l, input logic [6:0] c);
        return C_AW'(l) * C_AW'(COLS) + C_AW'(c);
    endfunction

    function automatic logic [6:0] col_ini(input int i);
        return 7'(col_inicio(i, N_JOG, COLS, BORDA));
    endfunction

    estado_t          estado_q, estado_d;
    fase_t            fase_q, fase_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [C_TW-1:0]  tmr_q, tmr_d;
    logic [C_AW-1:0]  varre_q, varre_d;
    logic [5:0]       vlin_q, vlin_d;
    logic [6:0]       vcol_q, vcol_d;
    logic [6:0]       col_q  [N_JOG];
    logic [6:0]       col_d  [N_JOG];
    logic [5:0]       lin_q  [N_JOG];
    logic [5:0]       lin_d  [N_JOG];
    logic [1:0]       dir_q  [N_JOG];
    logic [1:0]       dir_d  [N_JOG];
    logic [6:0]       ncol_q [N_JOG];
    logic [6:0]       ncol_d [N_JOG];
    logic [5:0]       nlin_q [N_JOG];
    logic [5:0]       nlin_d [N_JOG];
    logic [N_JOG-1:0] vivos_q, vivos_d;
    logic [N_JOG-1:0] morto_q, morto_d;
    logic [2:0]       vencedor_q, vencedor_d;
    logic             passo_q, passo_d;
    logic             rdok_q;

    logic             w_we_a;
    logic [C_AW-1:0]  w_addr_a, w_addr_b;
    logic [C_CW-1:0]  w_wdata_a, w_rdata_a, w_rdata_b;
    logic [N_JOG-1:0] w_colisao, w_sobrev;
    logic             w_parede, w_rd_ok;

    ram_grade #(
        .DEPTH (C_NCELL),
        .CW    (C_CW),
        .AW    (C_AW)
    ) u_ram (
        .clk_i     (CLOCK_50),
        .we_a_i    (w_we_a),
        .addr_a_i  (w_addr_a),
        .wdata_a_i (w_wdata_a),
        .rdata_a_o (w_rdata_a),
        .addr_b_i  (w_addr_b),
        .rdata_b_o (w_rdata_b)
    );

    assign w_parede = (vlin_q < C_LIN_MIN) || (vlin_q >= C_LIN_MAX) ||
                      (vcol_q < C_COL_MIN) || (vcol_q >= C_COL_MAX);
    assign w_rd_ok  = (rd_lin <= C_LIN_ULT) && (rd_col <= C_COL_ULT);
    assign w_addr_b = w_rd_ok ? endereco(rd_lin, rd_col) : '0;
    assign w_sobrev = vivos_q & ~morto_q;

    always_comb begin
        w_colisao = '0;
        for (int i = 0; i < N_JOG; i++) begin
            for (int j = 0; j < N_JOG; j++) begin
                if (i != j && vivos_q[i] && vivos_q[j] &&
                    ncol_q[i] == ncol_q[j] && nlin_q[i] == nlin_q[j]) begin
                    w_colisao[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        estado_d   = estado_q;
        fase_d     = fase_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        varre_d    = varre_q;
        vlin_d     = vlin_q;
        vcol_d     = vcol_q;
        col_d      = col_q;
        lin_d      = lin_q;
        dir_d      = dir_q;
        ncol_d     = ncol_q;
        nlin_d     = nlin_q;
        vivos_d    = vivos_q;
        morto_d    = morto_q;
        vencedor_d = vencedor_q;
        passo_d    = 1'b0;
        w_we_a     = 1'b0;
        w_addr_a   = varre_q;
        w_wdata_a  = '0;

        for (int i = 0; i < N_JOG; i++) begin
            if ((estado_q == JOGA || estado_q == PAUSA) && (gira_h[i] ^ gira_ah[i])) begin
                dir_d[i] = gira_h[i] ? dir_q[i] + 2'd1 : dir_q[i] - 2'd1;
            end
        end

        if (estado_q == JOGA) begin
            tmr_d = (tmr_q == C_TMR_FIM) ? '0 : tmr_q + 1'b1;
        end

        case (estado_q)
            LIMPA: begin
                w_we_a    = 1'b1;
                w_wdata_a = w_parede ? C_PAREDE : '0;
                for (int i = 0; i < N_JOG; i++) begin
                    if (!w_parede && vlin_q == C_LIN_INI && vcol_q == col_ini(i)) begin
                        w_wdata_a = C_CW'(cod_celula(i, N_JOG, 1'b0));
                    end
                end
                varre_d = varre_q + 1'b1;
                if (vcol_q == C_COL_ULT) begin
                    vcol_d = '0;
                    vlin_d = vlin_q + 6'd1;
                end else begin
                    vcol_d = vcol_q + 7'd1;
                end
                if (varre_q == C_ULT_CEL) begin
                    estado_d = JOGA;
                    varre_d  = '0;
                    vlin_d   = '0;
                    vcol_d   = '0;
                end
            end
            JOGA:    if (pausa)  estado_d = PAUSA;
            PAUSA:   if (!pausa) estado_d = JOGA;
            default: ;
        endcase

        case (fase_q)
            F_OCIOSO: begin
                if (estado_q == JOGA && tmr_q == C_TMR_FIM) fase_d = F_CALC;
            end
            F_CALC: begin
                for (int i = 0; i < N_JOG; i++) begin
                    ncol_d[i] = col_q[i];
                    nlin_d[i] = lin_q[i];
                    if (vivos_q[i]) begin
                        case (dir_q[i])
                            C_DIR_DIREITA:  ncol_d[i] = col_q[i] + 7'd1;
                            C_DIR_BAIXO:    nlin_d[i] = lin_q[i] + 6'd1;
                            C_DIR_ESQUERDA: ncol_d[i] = col_q[i] - 7'd1;
                            default:        nlin_d[i] = lin_q[i] - 6'd1;
                        endcase
                    end
                end
                morto_d = '0;
                cnt_d   = '0;
                fase_d  = F_AVALIA;
            end
            F_AVALIA: begin
                // Read for player k is issued at count k; its data is judged at count k+1.
                for (int i = 0; i < N_JOG; i++) begin
                    if (cnt_q == 3'(i)) w_addr_a = endereco(nlin_q[i], ncol_q[i]);
                    if (cnt_q == 3'(i + 1) && w_rdata_a != '0) morto_d[i] = 1'b1;
                end
                if (cnt_q == C_ULT_AVAL) begin
                    morto_d = morto_d | w_colisao;
                    cnt_d   = '0;
                    fase_d  = F_GRAVA;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                for (int i = 0; i < N_JOG; i++) begin
                    if (cnt_q == 3'(i) && w_sobrev[i]) begin
                        w_we_a    = 1'b1;
                        w_addr_a  = endereco(nlin_q[i], ncol_q[i]);
                        w_wdata_a = C_CW'(cod_celula(i, N_JOG, 1'b0));
                    end
                end
                if (cnt_q == C_ULT_GRAVA) begin
                    fase_d  = F_OCIOSO;
                    cnt_d   = '0;
                    passo_d = 1'b1;
                    vivos_d = w_sobrev;
                    for (int i = 0; i < N_JOG; i++) begin
                        if (w_sobrev[i]) begin
                            col_d[i] = ncol_q[i];
                            lin_d[i] = nlin_q[i];
                        end
                    end
                    if ($countones(w_sobrev) <= 1) begin
                        estado_d   = FIM;
                        vencedor_d = '0;
                        for (int i = 0; i < N_JOG; i++) begin
                            if (w_sobrev[i]) vencedor_d = 3'(i + 1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
        endcase

        // Restart wins over everything, including a write already on port A.
        if (reiniciar) begin
            estado_d   = LIMPA;
            fase_d     = F_OCIOSO;
            cnt_d      = '0;
            tmr_d      = '0;
            varre_d    = '0;
            vlin_d     = '0;
            vcol_d     = '0;
            vivos_d    = '1;
            morto_d    = '0;
            vencedor_d = '0;
            passo_d    = 1'b0;
            w_we_a     = 1'b0;
            for (int i = 0; i < N_JOG; i++) begin
                col_d[i]  = col_ini(i);
                lin_d[i]  = C_LIN_INI;
                dir_d[i]  = dir_inicio(i);
                ncol_d[i] = col_ini(i);
                nlin_d[i] = C_LIN_INI;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            estado_q   <= LIMPA;
            fase_q     <= F_OCIOSO;
            cnt_q      <= '0;
            tmr_q      <= '0;
            varre_q    <= '0;
            vlin_q     <= '0;
            vcol_q     <= '0;
            vivos_q    <= '1;
            morto_q    <= '0;
            vencedor_q <= '0;
            passo_q    <= 1'b0;
            rdok_q     <= 1'b0;
            for (int i = 0; i < N_JOG; i++) begin
                col_q[i]  <= col_ini(i);
                lin_q[i]  <= C_LIN_INI;
                dir_q[i]  <= dir_inicio(i);
                ncol_q[i] <= col_ini(i);
                nlin_q[i] <= C_LIN_INI;
            end
        end else begin
            estado_q   <= estado_d;
            fase_q     <= fase_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            varre_q    <= varre_d;
            vlin_q     <= vlin_d;
            vcol_q     <= vcol_d;
            vivos_q    <= vivos_d;
            morto_q    <= morto_d;
            vencedor_q <= vencedor_d;
            passo_q    <= passo_d;
            rdok_q     <= w_rd_ok;
            col_q      <= col_d;
            lin_q      <= lin_d;
            dir_q      <= dir_d;
            ncol_q     <= ncol_d;
            nlin_q     <= nlin_d;
        end
    end

    generate
        for (genvar gi = 0; gi < N_JOG; gi++) begin : g_cab
            assign cab_col[7*gi +: 7] = col_q[gi];
            assign cab_lin[6*gi +: 6] = lin_q[gi];
        end
    endgenerate

    assign rd_dado  = rdok_q ? w_rdata_b : '0;
    assign vivos    = vivos_q;
    assign estado   = estado_q;
    assign vencedor = vencedor_q;
    assign passo_ok = passo_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_grade_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_grade_n
// Brief    : Directed self-checking bench for the light-cycle grid engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_grade_n;

    localparam int N_JOG   = 2;
    localparam int COLS    = 16;
    localparam int ROWS    = 12;
    localparam int BORDA   = 1;
    localparam int PERIODO = 8;

    logic        clk = 1'b0;
    logic        reset_n, reiniciar, pausa;
    logic [1:0]  gira_h, gira_ah;
    logic [6:0]  rd_col;
    logic [5:0]  rd_lin;
    logic [1:0]  rd_dado;
    logic [13:0] cab_col;
    logic [11:0] cab_lin;
    logic [1:0]  vivos, estado;
    logic [2:0]  vencedor;
    logic        passo_ok;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    motor_grade_n #(
        .N_JOG(N_JOG), .COLS(COLS), .ROWS(ROWS), .BORDA(BORDA), .PERIODO(PERIODO)
    ) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .reiniciar(reiniciar),
        .pausa    (pausa),
        .gira_h   (gira_h),
        .gira_ah  (gira_ah),
        .rd_col   (rd_col),
        .rd_lin   (rd_lin),
        .rd_dado  (rd_dado),
        .cab_col  (cab_col),
        .cab_lin  (cab_lin),
        .vivos    (vivos),
        .estado   (estado),
        .vencedor (vencedor),
        .passo_ok (passo_ok)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] hcol(input int i);
        return cab_col[7*i +: 7];
    endfunction

    function automatic logic [5:0] hlin(input int i);
        return cab_lin[6*i +: 6];
    endfunction

    task automatic wait_joga(input string tag);
        int n = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            n++;
            if (estado == 2'd1) break;
        end
        check_eq(tag, n, ROWS * COLS);
    endtask

    task automatic wait_passo(input string tag);
        for (int k = 0; k < 60; k++) begin
            tick();
            if (passo_ok) break;
        end
        check_eq(tag, passo_ok, 1);
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] l, input logic [6:0] c, input int exp);
        rd_lin = l;
        rd_col = c;
        tick();
        check_eq(tag, rd_dado, exp);
    endtask

    task automatic pulse_restart();
        reiniciar = 1'b1;
        tick();
        reiniciar = 1'b0;
    endtask

    initial begin
        int n, np;
        reset_n = 1'b0; reiniciar = 1'b0; pausa = 1'b0;
        gira_h = '0; gira_ah = '0; rd_col = '0; rd_lin = '0;
        repeat (3) tick();

        check_eq("rst_estado", estado, 0);
        check_eq("rst_vivos", vivos, 3);
        check_eq("rst_vencedor", vencedor, 0);
        check_eq("rst_passo", passo_ok, 0);
        check_eq("rst_rd_dado", rd_dado, 0);
        check_eq("rst_p0_col", hcol(0), 5);
        check_eq("rst_p1_col", hcol(1), 10);
        check_eq("rst_p0_lin", hlin(0), 6);
        check_eq("rst_p1_lin", hlin(1), 6);

        // Sweep length, then first step latency from the first JOGA cycle.
        reset_n = 1'b1;
        wait_joga("sweep_len");
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            n++;
            if (passo_ok) break;
        end
        check_eq("step1_latency", n, (PERIODO - 1) + 2 * N_JOG + 3);
        check_eq("step1_p0_col", hcol(0), 6);
        check_eq("step1_p1_col", hcol(1), 9);
        check_eq("step1_p0_lin", hlin(0), 6);
        check_eq("step1_vivos", vivos, 3);

        pausa = 1'b1;
        tick();
        check_eq("pause_estado", estado, 2);
        rd_chk("cell_0_0", 6'd0, 7'd0, 3);
        rd_chk("cell_5_5", 6'd5, 7'd5, 0);
        rd_chk("cell_6_5", 6'd6, 7'd5, 1);
        rd_chk("cell_6_6", 6'd6, 7'd6, 1);
        rd_chk("cell_6_9", 6'd6, 7'd9, 2);
        rd_chk("cell_6_10", 6'd6, 7'd10, 2);
        rd_chk("cell_11_15", 6'd11, 7'd15, 3);
        rd_chk("cell_out_row", 6'd12, 7'd0, 0);
        rd_chk("cell_out_col", 6'd0, 7'd16, 0);

        np = 0;
        repeat (50) begin
            tick();
            if (passo_ok) np++;
        end
        check_eq("pause_no_step", np, 0);
        check_eq("pause_p0_col", hcol(0), 6);
        check_eq("pause_p1_col", hcol(1), 9);

        // Head-on: step 2 brings them adjacent, step 3 swaps and kills both.
        pausa = 1'b0;
        wait_passo("step2_seen");
        check_eq("step2_p0_col", hcol(0), 7);
        check_eq("step2_p1_col", hcol(1), 8);
        wait_passo("step3_seen");
        check_eq("headon_vivos", vivos, 0);
        check_eq("headon_estado", estado, 3);
        check_eq("headon_vencedor", vencedor, 0);
        gira_h = 2'b11;
        tick();
        gira_h = 2'b00;
        np = 0;
        repeat (20) begin
            tick();
            if (passo_ok) np++;
        end
        check_eq("fim_holds", estado, 3);
        check_eq("fim_no_step", np, 0);

        // Wall win: p0 heads up, p1 heads down into the bottom wall on step 5.
        pulse_restart();
        check_eq("restart_estado", estado, 0);
        check_eq("restart_vivos", vivos, 3);
        check_eq("restart_p0_col", hcol(0), 5);
        check_eq("restart_p1_col", hcol(1), 10);
        wait_joga("sweep_len_2");
        gira_ah = 2'b11;
        tick();
        gira_ah = 2'b00;
        repeat (4) wait_passo("wall_step");
        check_eq("wall_s4_p0_lin", hlin(0), 2);
        check_eq("wall_s4_p1_lin", hlin(1), 10);
        wait_passo("wall_step5");
        check_eq("wall_vivos", vivos, 1);
        check_eq("wall_estado", estado, 3);
        check_eq("wall_vencedor", vencedor, 1);
        check_eq("wall_p0_lin", hlin(0), 1);
        check_eq("wall_p0_col", hcol(0), 5);
        check_eq("wall_p1_lin", hlin(1), 10);

        // Simultaneous h/ah on p0 is ignored; lone h on p1 turns it upward.
        pulse_restart();
        wait_joga("sweep_len_3");
        gira_h  = 2'b11;
        gira_ah = 2'b01;
        tick();
        gira_h  = 2'b00;
        gira_ah = 2'b00;
        wait_passo("turn_step");
        check_eq("turn_p0_col", hcol(0), 6);
        check_eq("turn_p0_lin", hlin(0), 6);
        check_eq("turn_p1_col", hcol(1), 10);
        check_eq("turn_p1_lin", hlin(1), 5);

        // Restart landing in the first GRAVA cycle of step 1.
        pulse_restart();
        wait_joga("sweep_len_4");
        repeat (12) tick();
        pulse_restart();
        check_eq("abort_estado", estado, 0);
        check_eq("abort_passo", passo_ok, 0);
        check_eq("abort_vivos", vivos, 3);
        check_eq("abort_p0_col", hcol(0), 5);
        check_eq("abort_p1_col", hcol(1), 10);
        wait_joga("sweep_len_5");
        pausa = 1'b1;
        tick();
        rd_chk("abort_cell_6_6", 6'd6, 7'd6, 0);
        rd_chk("abort_cell_6_9", 6'd6, 7'd9, 0);
        rd_chk("abort_cell_6_5", 6'd6, 7'd5, 1);
        rd_chk("abort_cell_6_10", 6'd6, 7'd10, 2);
        pausa = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
